// File: rtl/spi_frame_master.sv
// SPI mode-0 frame transmitter: sends {FIRST_BYTE, data[23:0]} MSB first inside one cs_n-low window.
// All outputs are registered; the next-state logic computes every next output value.
module spi_frame_master #(
  parameter int         SCLK_HALF  = 3,
  parameter int         CS_SETUP   = 2,
  parameter int         CS_HOLD    = 2,
  parameter int         CS_GAP     = 4,
  parameter logic [7:0] FIRST_BYTE = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [23:0] data,
  output logic        ready,
  output logic        done,
  output logic        spi_clk,
  output logic        spi_mosi,
  output logic        spi_cs_n
);

  localparam int MAX_A = (SCLK_HALF > CS_SETUP) ? SCLK_HALF : CS_SETUP;
  localparam int MAX_B = (CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP;
  localparam int MAX_T = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W = (MAX_T > 1) ? $clog2(MAX_T) : 1;

  localparam logic [CNT_W-1:0] HALF_TC  = CNT_W'(SCLK_HALF - 1);
  localparam logic [CNT_W-1:0] SETUP_TC = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] HOLD_TC  = CNT_W'(CS_HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_TC   = CNT_W'(CS_GAP - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [4:0]       bit_cnt, bit_cnt_n, bit_nxt;
  logic [31:0]      frame;
  logic             load;
  logic             ready_n, done_n, sclk_n, mosi_n, cs_n_n;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt + CNT_W'(1);
    bit_cnt_n = bit_cnt;
    bit_nxt   = bit_cnt - 5'd1;
    ready_n   = ready;
    done_n    = 1'b0;
    sclk_n    = spi_clk;
    mosi_n    = spi_mosi;
    cs_n_n    = spi_cs_n;
    load      = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (start) begin
          load    = 1'b1;
          state_n = SETUP;
          ready_n = 1'b0;
          cs_n_n  = 1'b0;
          mosi_n  = FIRST_BYTE[7];
        end
      end
      SETUP: begin
        if (cnt == SETUP_TC) begin
          state_n   = SHIFT;
          cnt_n     = '0;
          bit_cnt_n = 5'd31;
          mosi_n    = frame[31];
        end
      end
      SHIFT: begin
        // Each bit is a low half then a high half; mosi moves only as SCLK falls.
        if (cnt == HALF_TC) begin
          cnt_n = '0;
          if (!spi_clk) begin
            sclk_n = 1'b1;
          end else begin
            sclk_n = 1'b0;
            if (bit_cnt == 5'd0) begin
              state_n = HOLD;
            end else begin
              bit_cnt_n = bit_nxt;
              mosi_n    = frame[bit_nxt];
            end
          end
        end
      end
      HOLD: begin
        if (cnt == HOLD_TC) begin
          state_n = GAP;
          cnt_n   = '0;
          cs_n_n  = 1'b1;
          mosi_n  = 1'b0;
        end
      end
      GAP: begin
        if (cnt == GAP_TC) begin
          state_n = IDLE;
          cnt_n   = '0;
          ready_n = 1'b1;
          done_n  = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      ready    <= 1'b1;
      done     <= 1'b0;
      spi_clk  <= 1'b0;
      spi_mosi <= 1'b0;
      spi_cs_n <= 1'b1;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      bit_cnt  <= bit_cnt_n;
      ready    <= ready_n;
      done     <= done_n;
      spi_clk  <= sclk_n;
      spi_mosi <= mosi_n;
      spi_cs_n <= cs_n_n;
    end
  end

  // Payload register carries no reset; it is only read after a fresh load.
  always_ff @(posedge clk) begin
    if (load) frame <= {FIRST_BYTE, data};
  end

endmodule

// File: tb/tb_spi_frame_master.sv
// Directed bench for spi_frame_master: default instance plus a fast-parameter instance,
// with a cycle-sampled SPI monitor that captures frames, timing and pulses.
module tb_spi_frame_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start_a, start_b, sel;
  logic [23:0] data;
  logic a_ready, a_done, a_sclk, a_mosi, a_cs_n;
  logic b_ready, b_done, b_sclk, b_mosi, b_cs_n;
  logic o_ready, o_done, o_sclk, o_mosi, o_cs_n;

  spi_frame_master dut_a (
    .clk(clk), .rst(rst), .start(start_a), .data(data),
    .ready(a_ready), .done(a_done), .spi_clk(a_sclk), .spi_mosi(a_mosi), .spi_cs_n(a_cs_n)
  );

  spi_frame_master #(
    .SCLK_HALF(1), .CS_SETUP(1), .CS_HOLD(1), .CS_GAP(1), .FIRST_BYTE(8'h5A)
  ) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .data(data),
    .ready(b_ready), .done(b_done), .spi_clk(b_sclk), .spi_mosi(b_mosi), .spi_cs_n(b_cs_n)
  );

  always_comb begin
    o_ready = sel ? b_ready : a_ready;
    o_done  = sel ? b_done  : a_done;
    o_sclk  = sel ? b_sclk  : a_sclk;
    o_mosi  = sel ? b_mosi  : a_mosi;
    o_cs_n  = sel ? b_cs_n  : a_cs_n;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Monitor state
  logic [31:0] caps[4], rises[4], lows[4], gaps[4], dones[4];
  int ncap, ngap, ndone, cyc, stray, r1, r2, ready_rise;
  int cur_rises, cur_low, cur_high;
  logic [31:0] cur_cap;
  logic seen_end, prev_cs, prev_sclk, prev_ready;

  task automatic clear_mon();
    for (int i = 0; i < 4; i++) begin
      caps[i] = 'x; rises[i] = 'x; lows[i] = 'x; gaps[i] = 'x; dones[i] = 'x;
    end
    ncap = 0; ngap = 0; ndone = 0; cyc = 0; stray = 0;
    r1 = -1; r2 = -1; ready_rise = -1;
    cur_rises = 0; cur_low = 0; cur_high = 0; cur_cap = '0; seen_end = 1'b0;
    prev_cs = o_cs_n; prev_sclk = o_sclk; prev_ready = o_ready;
  endtask

  task automatic observe(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      cyc++;
      if (prev_cs && !o_cs_n) begin
        cur_cap = '0; cur_rises = 0; cur_low = 0;
        if (seen_end && ngap < 4) begin gaps[ngap] = cur_high; ngap++; end
      end
      if (!o_cs_n) begin
        cur_low++;
        if (!prev_sclk && o_sclk) begin
          cur_cap = {cur_cap[30:0], o_mosi};
          cur_rises++;
          if (cur_rises == 1 && r1 < 0) r1 = cyc;
          if (cur_rises == 2 && r2 < 0) r2 = cyc;
        end
      end else begin
        if (!prev_sclk && o_sclk) stray++;
        if (!prev_cs) begin
          if (ncap < 4) begin
            caps[ncap] = cur_cap; rises[ncap] = cur_rises; lows[ncap] = cur_low; ncap++;
          end
          seen_end = 1'b1;
          cur_high = 1;
        end else begin
          cur_high++;
        end
      end
      if (o_done && ndone < 4) begin dones[ndone] = cyc; ndone++; end
      if (o_ready && !prev_ready && ready_rise < 0) ready_rise = cyc;
      prev_cs = o_cs_n; prev_sclk = o_sclk; prev_ready = o_ready;
    end
  endtask

  initial begin
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; data = '0; sel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", a_ready, 1);
    check("rst_done", a_done, 0);
    check("rst_cs_n", a_cs_n, 1);
    check("rst_sclk", a_sclk, 0);
    check("rst_mosi", a_mosi, 0);
    check("rst_b_cs_n", b_cs_n, 1);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Basic frame at default timing
    clear_mon();
    data = 24'hA5C3F0; start_a = 1'b1;
    observe(1);
    start_a = 1'b0;
    check("t1_cs_low_t1", o_cs_n, 0);
    check("t1_ready_t1", o_ready, 0);
    check("t1_mosi_t1", o_mosi, 0);
    check("t1_sclk_t1", o_sclk, 0);
    observe(209);
    check("t1_ncap", ncap, 1);
    check("t1_cap", caps[0], 32'h00A5C3F0);
    check("t1_rises", rises[0], 32);
    check("t1_cs_low_len", lows[0], 196);
    check("t1_first_rise", r1, 6);
    check("t1_sclk_period", r2 - r1, 6);
    check("t1_stray", stray, 0);
    check("t1_ndone", ndone, 1);
    check("t1_done_cyc", dones[0], 201);
    check("t1_ready_cyc", ready_rise, 201);

    // Held start: back-to-back frames, data change after acceptance ignored
    clear_mon();
    data = 24'h000001; start_a = 1'b1;
    observe(1);
    data = 24'hFFFFFF;
    observe(205);
    start_a = 1'b0;
    observe(200);
    check("t3_ncap", ncap, 2);
    check("t3_cap0", caps[0], 32'h00000001);
    check("t3_cap1", caps[1], 32'h00FFFFFF);
    check("t3_gap", gaps[0], 5);
    check("t3_ndone", ndone, 2);
    check("t3_done0", dones[0], 201);
    check("t3_done1", dones[1], 402);

    // Start pulse mid-frame is ignored
    clear_mon();
    data = 24'hA5C3F0; start_a = 1'b1;
    observe(1);
    start_a = 1'b0;
    observe(49);
    data = 24'hDEADBE; start_a = 1'b1;
    observe(1);
    start_a = 1'b0;
    observe(159);
    check("t4_ncap", ncap, 1);
    check("t4_cap", caps[0], 32'h00A5C3F0);
    check("t4_ndone", ndone, 1);
    check("t4_done_cyc", dones[0], 201);
    check("t4_ready_cyc", ready_rise, 201);

    // Asynchronous reset in the middle of SHIFT
    clear_mon();
    data = 24'h123456; start_a = 1'b1;
    observe(1);
    start_a = 1'b0;
    observe(99);
    rst = 1'b1;
    #1;
    check("t5_cs_n", o_cs_n, 1);
    check("t5_sclk", o_sclk, 0);
    check("t5_mosi", o_mosi, 0);
    check("t5_ready", o_ready, 1);
    check("t5_done", o_done, 0);
    observe(3);
    rst = 1'b0;
    observe(210);
    check("t5_no_done", ndone, 0);
    clear_mon();
    data = 24'h654321; start_a = 1'b1;
    observe(1);
    start_a = 1'b0;
    observe(209);
    check("t5_cap_after", caps[0], 32'h00654321);
    check("t5_rises_after", rises[0], 32);
    check("t5_done_after", dones[0], 201);

    // Minimum timing parameters with a non-zero header
    sel = 1'b1;
    clear_mon();
    data = 24'h0F0F0F; start_b = 1'b1;
    observe(1);
    start_b = 1'b0;
    observe(80);
    check("t6_cap", caps[0], 32'h5A0F0F0F);
    check("t6_rises", rises[0], 32);
    check("t6_cs_low_len", lows[0], 66);
    check("t6_first_rise", r1, 3);
    check("t6_sclk_period", r2 - r1, 2);
    check("t6_ndone", ndone, 1);
    check("t6_done_cyc", dones[0], 68);
    check("t6_stray", stray, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
